// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: check-bit count derivation and Hamming position map.
// All functions are constant-evaluable so they can size ports and drive generate loops.
package ecc_pkg;

  localparam int unsigned MaxCodeW = 64;

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned calc_p(input int unsigned data_w);
    int unsigned p = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << p) < data_w + p + 1) p++;
    end
    return p;
  endfunction

  function automatic int unsigned code_w(input int unsigned data_w);
    return data_w + calc_p(data_w) + 1;
  endfunction

  // Data-bit number carried at a non-power-of-two Hamming position.
  function automatic int unsigned data_index(input int unsigned pos);
    int unsigned n = 0;
    for (int unsigned q = 1; q < 128; q++) begin
      if (q < pos && !is_pow2(q)) n++;
    end
    return n;
  endfunction

  // Positions 1..cw-1 whose index has bit k set.
  function automatic logic [MaxCodeW-1:0] check_mask(input int unsigned k, input int unsigned cw);
    logic [MaxCodeW-1:0] m = '0;
    for (int unsigned p = 1; p < MaxCodeW; p++) begin
      if (p < cw && ((p >> k) & 1) != 0) m = m | (MaxCodeW'(1) << p);
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// Streaming request/response bundle for the SECDED pipe.
// master drives beats in and accepts results; slave is the pipe itself.
interface ecc_secded_pipe_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CODE_W = ecc_pkg::code_w(DATA_W);

  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_data;
  logic              out_err_single;
  logic              out_err_double;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_single, out_err_double
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_single, out_err_double
  );

endinterface

// File: rtl/ecc_syndrome.sv
// Combinational Hamming syndrome plus overall parity of a codeword.
// Check positions are zero during encode, so the same syndrome yields the check bits.
module ecc_syndrome
  import ecc_pkg::*;
#(
  parameter int unsigned CODE_W = 13,
  parameter int unsigned P      = 4
) (
  input  logic [CODE_W-1:0] word,
  output logic [P-1:0]      syndrome,
  output logic              parity
);

  for (genvar k = 0; k < P; k++) begin : g_chk
    localparam logic [MaxCodeW-1:0] Mask = check_mask(k, CODE_W);
    assign syndrome[k] = ^(word & Mask[CODE_W-1:0]);
  end

  assign parity = ^word;

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED encode/decode pipeline with a saturating error counter.
// Stage 1 holds the raw beat, stage 2 the computed result; one shared syndrome unit.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  ecc_secded_pipe_if.slave    bus,
  input  logic                clr_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int unsigned P      = calc_p(DATA_W);
  localparam int unsigned CODE_W = code_w(DATA_W);

  logic              s1_valid_q, s1_mode_q;
  logic [CODE_W-1:0] s1_data_q;
  logic              s2_valid_q, s2_single_q, s2_double_q;
  logic [CODE_W-1:0] s2_data_q;
  logic [CNT_W-1:0]  err_count_q;

  logic              advance, s1_load, out_fire;
  logic [CODE_W-1:0] placed, enc_word, syn_in, hit, fixed_word;
  logic [DATA_W-1:0] dec_data;
  logic [P-1:0]      syn;
  logic              par, in_range, dec_single, dec_double;
  logic [CODE_W-1:0] res_data;
  logic              res_single, res_double;

  // Global stall: everything moves only when stage 2 can hand off.
  assign advance     = !s2_valid_q || bus.out_ready;
  assign s1_load     = advance || !s1_valid_q;
  assign bus.in_ready = s1_load;

  assign syn_in = s1_mode_q ? s1_data_q : placed;

  ecc_syndrome #(
    .CODE_W (CODE_W),
    .P      (P)
  ) u_syndrome (
    .word     (syn_in),
    .syndrome (syn),
    .parity   (par)
  );

  assign placed[0]   = 1'b0;
  assign enc_word[0] = par ^ (^syn);

  for (genvar pos = 1; pos < CODE_W; pos++) begin : g_pos
    if (is_pow2(pos)) begin : g_check
      assign placed[pos]   = 1'b0;
      assign enc_word[pos] = syn[$clog2(pos)];
    end else begin : g_data
      assign placed[pos]                  = s1_data_q[data_index(pos)];
      assign enc_word[pos]                = placed[pos];
      assign dec_data[data_index(pos)]    = fixed_word[pos];
    end
  end

  // hit[i] marks the position named by the syndrome; no bit set means S is out of range.
  for (genvar pos = 0; pos < CODE_W; pos++) begin : g_hit
    localparam logic [P-1:0] PosIdx = P'(pos);
    assign hit[pos] = (syn == PosIdx);
  end

  assign in_range   = |hit;
  assign fixed_word = par ? (s1_data_q ^ hit) : s1_data_q;
  assign dec_single = par && in_range;
  assign dec_double = par ? !in_range : (syn != '0);

  always_comb begin
    res_data   = enc_word;
    res_single = 1'b0;
    res_double = 1'b0;
    if (s1_mode_q) begin
      res_data   = {{(CODE_W - DATA_W){1'b0}}, dec_data};
      res_single = dec_single;
      res_double = dec_double;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_data_q  <= '0;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_q <= bus.mode;
        s1_data_q <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q   <= res_data;
        s2_single_q <= res_single;
        s2_double_q <= res_double;
      end
    end
  end

  assign out_fire = s2_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || clr_count) begin
      err_count_q <= '0;
    end else if (out_fire && (s2_single_q || s2_double_q) && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign bus.out_valid      = s2_valid_q;
  assign bus.out_data       = s2_data_q;
  assign bus.out_err_single = s2_single_q;
  assign bus.out_err_double = s2_double_q;
  assign err_count          = err_count_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed + randomized-stall bench for ecc_secded_pipe with a result scoreboard.
module tb_ecc_secded_pipe;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CODE_W = 13;

  typedef struct packed {
    logic [CODE_W-1:0] data;
    logic              s;
    logic              d;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] err_count;

  ecc_secded_pipe_if #(.DATA_W(DATA_W)) bus ();

  ecc_secded_pipe #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int               total = 0;
  int               bad = 0;
  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               ready_mode = 0;  // 0: always ready, 1: random, 2: never
  bit               prev_stall = 1'b0;
  logic [CODE_W-1:0] prev_data;
  logic             prev_s, prev_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [CODE_W-1:0] m_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] w = '0;
    int j = 0;
    logic p;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        w[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CODE_W; pos++) if ((pos & (1 << k)) != 0) p = p ^ w[pos];
      w[1 << k] = p;
    end
    w[0] = ^w[CODE_W-1:1];
    return w;
  endfunction

  function automatic exp_t m_decode(input logic [CODE_W-1:0] w);
    exp_t e;
    int s = 0;
    logic o;
    logic [CODE_W-1:0] f = w;
    logic [DATA_W-1:0] d = '0;
    int j = 0;
    o = ^w;
    for (int pos = 1; pos < CODE_W; pos++) if (w[pos]) s = s ^ pos;
    if (o && s > 0 && s < CODE_W) f[s] = ~f[s];
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        d[j] = f[pos];
        j++;
      end
    end
    e.data = {5'b0, d};
    e.s    = o && (s < CODE_W);
    e.d    = o ? (s >= CODE_W) : (s != 0);
    return e;
  endfunction

  // Monitor: pop/compare on transfers, check stall stability, track the counter.
  always @(negedge clk) begin
    exp_t e;
    bit   err_fire;
    if (reset) begin
      prev_stall = 1'b0;
      exp_cnt    = '0;
    end else begin
      err_fire = 1'b0;
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), 32'(prev_data));
        chk("stall_flags", 32'({bus.out_err_single, bus.out_err_double}),
            32'({prev_s, prev_d}));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.data));
          chk("err_single", 32'(bus.out_err_single), 32'(e.s));
          chk("err_double", 32'(bus.out_err_double), 32'(e.d));
          err_fire = e.s || e.d;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_s     = bus.out_err_single;
      prev_d     = bus.out_err_double;
      if (clr_count) exp_cnt = '0;
      else if (err_fire && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 2) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic m, input logic [CODE_W-1:0] din, input exp_t e);
    bit acc = 1'b0;
    int n = 0;
    bus.mode     = m;
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
    end
    if (acc) sb.push_back(e);
    chk("send_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic cnt_is(input string tag, input logic [CNT_W-1:0] want);
    @(negedge clk);
    chk(tag, 32'(err_count), 32'(want));
    tick();
  endtask

  initial begin
    logic [DATA_W-1:0] r;
    logic [CODE_W-1:0] w;
    int                n;

    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_flags", 32'({bus.out_err_single, bus.out_err_double}), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Encode vectors with a latency probe.
    send(1'b0, 13'h0000, '{data: 13'h0000, s: 1'b0, d: 1'b0});
    @(negedge clk);
    chk("lat_cycle1", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_cycle2", 32'(bus.out_valid), 32'd1);
    tick();
    send(1'b0, 13'h00FF, '{data: 13'h1EEE, s: 1'b0, d: 1'b0});
    drain();

    // Decode vectors: clean, single in a data position, single in overall parity.
    send(1'b1, 13'h1EEE, '{data: 13'h00FF, s: 1'b0, d: 1'b0});
    send(1'b1, 13'h1ECE, '{data: 13'h00FF, s: 1'b1, d: 1'b0});
    send(1'b1, 13'h1EEF, '{data: 13'h00FF, s: 1'b1, d: 1'b0});
    drain();
    cnt_is("cnt_after_singles", 2'd2);

    // Double error bumps the counter by exactly one.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    send(1'b1, 13'h1CCE, m_decode(13'h1CCE));
    drain();
    cnt_is("cnt_after_double", 2'd1);

    // Saturation with CNT_W=2.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    send(1'b1, 13'h1ECE, '{data: 13'h00FF, s: 1'b1, d: 1'b0});
    send(1'b1, 13'h1CCE, m_decode(13'h1CCE));
    send(1'b1, 13'h1EEF, '{data: 13'h00FF, s: 1'b1, d: 1'b0});
    send(1'b1, 13'h1CCE, m_decode(13'h1CCE));
    drain();
    cnt_is("cnt_saturated", 2'd3);

    // Clear in the same cycle as an erroneous output transfer.
    ready_mode = 2;
    send(1'b1, 13'h1ECE, '{data: 13'h00FF, s: 1'b1, d: 1'b0});
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      tick();
      n++;
    end
    chk("stalled_beat_ready", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    clr_count     = 1'b1;
    ready_mode    = 0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    @(negedge clk);
    chk("clr_beats_inc", 32'(err_count), 32'd0);
    chk("clr_beat_popped", 32'(sb.size()), 32'd0);
    tick();

    // Alternating encode/decode, back to back, random downstream stalls.
    ready_mode = 1;
    for (int i = 0; i < 16; i++) begin
      r = DATA_W'($urandom);
      if (i % 2 == 0) begin
        w = CODE_W'($urandom);
        w[DATA_W-1:0] = r;
        send(1'b0, w, '{data: m_encode(r), s: 1'b0, d: 1'b0});
      end else begin
        w = m_encode(r);
        n = $urandom_range(0, 2);
        if (n >= 1) w[$urandom_range(0, CODE_W - 1)] ^= 1'b1;
        if (n == 2) w[$urandom_range(0, CODE_W - 1)] ^= 1'b1;
        send(1'b1, w, m_decode(w));
      end
    end
    drain();
    ready_mode = 0;
    tick();

    // Reset with both stages full: nothing in flight may emerge.
    clr_count = 1'b1;
    tick();
    clr_count  = 1'b0;
    ready_mode = 2;
    send(1'b0, 13'h0055, '{data: m_encode(8'h55), s: 1'b0, d: 1'b0});
    send(1'b0, 13'h00AA, '{data: m_encode(8'hAA), s: 1'b0, d: 1'b0});
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    ready_mode = 0;
    repeat (8) tick();
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
